// File: rtl/ysyx_23060059_axi_arbiter.sv
// Two-master AXI4 arbiter: IFU (m0, read-only) and LSU (m1, read/write) share one slave port.
// One transaction outstanding; reads round-robin, a pending LSU write beats any read.
module ysyx_23060059_axi_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 64,
  parameter int unsigned IDW = 4
) (
  input  logic             clock,
  input  logic             reset,
  // IFU read
  input  logic             m0_arvalid,
  output logic             m0_arready,
  input  logic [AW-1:0]    m0_araddr,
  input  logic [IDW-1:0]   m0_arid,
  input  logic [7:0]       m0_arlen,
  input  logic [2:0]       m0_arsize,
  input  logic [1:0]       m0_arburst,
  output logic             m0_rvalid,
  input  logic             m0_rready,
  output logic [DW-1:0]    m0_rdata,
  output logic [1:0]       m0_rresp,
  output logic             m0_rlast,
  output logic [IDW-1:0]   m0_rid,
  // LSU read
  input  logic             m1_arvalid,
  output logic             m1_arready,
  input  logic [AW-1:0]    m1_araddr,
  input  logic [IDW-1:0]   m1_arid,
  input  logic [7:0]       m1_arlen,
  input  logic [2:0]       m1_arsize,
  input  logic [1:0]       m1_arburst,
  output logic             m1_rvalid,
  input  logic             m1_rready,
  output logic [DW-1:0]    m1_rdata,
  output logic [1:0]       m1_rresp,
  output logic             m1_rlast,
  output logic [IDW-1:0]   m1_rid,
  // LSU write
  input  logic             m1_awvalid,
  output logic             m1_awready,
  input  logic [AW-1:0]    m1_awaddr,
  input  logic [IDW-1:0]   m1_awid,
  input  logic [7:0]       m1_awlen,
  input  logic [2:0]       m1_awsize,
  input  logic [1:0]       m1_awburst,
  input  logic             m1_wvalid,
  output logic             m1_wready,
  input  logic [DW-1:0]    m1_wdata,
  input  logic [DW/8-1:0]  m1_wstrb,
  input  logic             m1_wlast,
  output logic             m1_bvalid,
  input  logic             m1_bready,
  output logic [1:0]       m1_bresp,
  output logic [IDW-1:0]   m1_bid,
  // slave port
  output logic             s_arvalid,
  input  logic             s_arready,
  output logic [AW-1:0]    s_araddr,
  output logic [IDW-1:0]   s_arid,
  output logic [7:0]       s_arlen,
  output logic [2:0]       s_arsize,
  output logic [1:0]       s_arburst,
  input  logic             s_rvalid,
  output logic             s_rready,
  input  logic [DW-1:0]    s_rdata,
  input  logic [1:0]       s_rresp,
  input  logic             s_rlast,
  input  logic [IDW-1:0]   s_rid,
  output logic             s_awvalid,
  input  logic             s_awready,
  output logic [AW-1:0]    s_awaddr,
  output logic [IDW-1:0]   s_awid,
  output logic [7:0]       s_awlen,
  output logic [2:0]       s_awsize,
  output logic [1:0]       s_awburst,
  output logic             s_wvalid,
  input  logic             s_wready,
  output logic [DW-1:0]    s_wdata,
  output logic [DW/8-1:0]  s_wstrb,
  output logic             s_wlast,
  input  logic             s_bvalid,
  output logic             s_bready,
  input  logic [1:0]       s_bresp,
  input  logic [IDW-1:0]   s_bid,
  output logic             busy,
  output logic [1:0]       grant
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] R_ADDR = 3'd1;
  localparam logic [2:0] R_DATA = 3'd2;
  localparam logic [2:0] W_DATA = 3'd3;
  localparam logic [2:0] W_RESP = 3'd4;

  logic [2:0] state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_rd_q, last_rd_d;  // 1 = m1 owned the last read
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_rd_q <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_rd_q <= last_rd_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign grant = grant_q;

  // Next-state and channel routing; every channel is closed in IDLE.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_rd_d = last_rd_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    m0_arready = 1'b0; m0_rvalid = 1'b0; m0_rdata = '0; m0_rresp = 2'b00; m0_rlast = 1'b0; m0_rid = '0;
    m1_arready = 1'b0; m1_rvalid = 1'b0; m1_rdata = '0; m1_rresp = 2'b00; m1_rlast = 1'b0; m1_rid = '0;
    m1_awready = 1'b0; m1_wready = 1'b0; m1_bvalid = 1'b0; m1_bresp = 2'b00; m1_bid = '0;
    s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = 8'd0; s_arsize = 3'd0; s_arburst = 2'b00;
    s_rready  = 1'b0;
    s_awvalid = 1'b0; s_awaddr = '0; s_awid = '0; s_awlen = 8'd0; s_awsize = 3'd0; s_awburst = 2'b00;
    s_wvalid  = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0;
    s_bready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m1_awvalid) begin
          state_d = W_DATA;
          grant_d = 2'b10;
        end else if (m0_arvalid && m1_arvalid) begin
          state_d = R_ADDR;
          grant_d = last_rd_q ? 2'b01 : 2'b10;
        end else if (m0_arvalid) begin
          state_d = R_ADDR;
          grant_d = 2'b01;
        end else if (m1_arvalid) begin
          state_d = R_ADDR;
          grant_d = 2'b10;
        end
      end
      R_ADDR: begin
        if (grant_q[1]) begin
          s_arvalid = m1_arvalid; s_araddr = m1_araddr; s_arid = m1_arid;
          s_arlen = m1_arlen; s_arsize = m1_arsize; s_arburst = m1_arburst;
          m1_arready = s_arready;
        end else begin
          s_arvalid = m0_arvalid; s_araddr = m0_araddr; s_arid = m0_arid;
          s_arlen = m0_arlen; s_arsize = m0_arsize; s_arburst = m0_arburst;
          m0_arready = s_arready;
        end
        if (s_arvalid && s_arready) state_d = R_DATA;
      end
      R_DATA: begin
        if (grant_q[1]) begin
          s_rready = m1_rready;
          m1_rvalid = s_rvalid; m1_rdata = s_rdata; m1_rresp = s_rresp; m1_rlast = s_rlast; m1_rid = s_rid;
        end else begin
          s_rready = m0_rready;
          m0_rvalid = s_rvalid; m0_rdata = s_rdata; m0_rresp = s_rresp; m0_rlast = s_rlast; m0_rid = s_rid;
        end
        if (s_rvalid && s_rready && s_rlast) begin
          state_d   = IDLE;
          grant_d   = 2'b00;
          last_rd_d = grant_q[1];
        end
      end
      W_DATA: begin
        // AW and W complete independently; each side is masked once done.
        s_awvalid = m1_awvalid & ~aw_done_q;
        s_awaddr = m1_awaddr; s_awid = m1_awid; s_awlen = m1_awlen;
        s_awsize = m1_awsize; s_awburst = m1_awburst;
        m1_awready = s_awready & ~aw_done_q;
        s_wvalid = m1_wvalid & ~w_done_q;
        s_wdata = m1_wdata; s_wstrb = m1_wstrb; s_wlast = m1_wlast;
        m1_wready = s_wready & ~w_done_q;
        if (s_awvalid && s_awready) aw_done_d = 1'b1;
        if (s_wvalid && s_wready && m1_wlast) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_RESP: begin
        s_bready  = m1_bready;
        m1_bvalid = s_bvalid; m1_bresp = s_bresp; m1_bid = s_bid;
        if (s_bvalid && s_bready) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_ysyx_23060059_axi_arbiter.sv
// Bench for the IFU/LSU AXI arbiter: directed scenarios plus randomized requests
// checked against a grant-order model (write first, otherwise round-robin on ties).
module tb_ysyx_23060059_axi_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned IDW = 4;

  logic clock, reset;
  logic m0_arvalid, m0_arready; logic [AW-1:0] m0_araddr; logic [IDW-1:0] m0_arid;
  logic [7:0] m0_arlen; logic [2:0] m0_arsize; logic [1:0] m0_arburst;
  logic m0_rvalid, m0_rready; logic [DW-1:0] m0_rdata; logic [1:0] m0_rresp; logic m0_rlast; logic [IDW-1:0] m0_rid;
  logic m1_arvalid, m1_arready; logic [AW-1:0] m1_araddr; logic [IDW-1:0] m1_arid;
  logic [7:0] m1_arlen; logic [2:0] m1_arsize; logic [1:0] m1_arburst;
  logic m1_rvalid, m1_rready; logic [DW-1:0] m1_rdata; logic [1:0] m1_rresp; logic m1_rlast; logic [IDW-1:0] m1_rid;
  logic m1_awvalid, m1_awready; logic [AW-1:0] m1_awaddr; logic [IDW-1:0] m1_awid;
  logic [7:0] m1_awlen; logic [2:0] m1_awsize; logic [1:0] m1_awburst;
  logic m1_wvalid, m1_wready; logic [DW-1:0] m1_wdata; logic [DW/8-1:0] m1_wstrb; logic m1_wlast;
  logic m1_bvalid, m1_bready; logic [1:0] m1_bresp; logic [IDW-1:0] m1_bid;
  logic s_arvalid, s_arready; logic [AW-1:0] s_araddr; logic [IDW-1:0] s_arid;
  logic [7:0] s_arlen; logic [2:0] s_arsize; logic [1:0] s_arburst;
  logic s_rvalid, s_rready; logic [DW-1:0] s_rdata; logic [1:0] s_rresp; logic s_rlast; logic [IDW-1:0] s_rid;
  logic s_awvalid, s_awready; logic [AW-1:0] s_awaddr; logic [IDW-1:0] s_awid;
  logic [7:0] s_awlen; logic [2:0] s_awsize; logic [1:0] s_awburst;
  logic s_wvalid, s_wready; logic [DW-1:0] s_wdata; logic [DW/8-1:0] s_wstrb; logic s_wlast;
  logic s_bvalid, s_bready; logic [1:0] s_bresp; logic [IDW-1:0] s_bid;
  logic busy; logic [1:0] grant;

  int n_chk = 0;
  int n_fail = 0;
  int last_rd_m;  // model: index of master that owned the last completed read

  ysyx_23060059_axi_arbiter #(.AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
    .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .busy(busy), .grant(grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [1:0] oh(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic clear_inputs();
    m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = 0; m0_arsize = 3'd3; m0_arburst = 2'b01; m0_rready = 1;
    m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = 0; m1_arsize = 3'd3; m1_arburst = 2'b01; m1_rready = 1;
    m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_awlen = 0; m1_awsize = 3'd3; m1_awburst = 2'b01;
    m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_bready = 1;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = 0; s_rlast = 0; s_rid = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0; s_bid = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    repeat (2) @(negedge clock);
    reset = 0;
    last_rd_m = 1;
    #1;
  endtask

  // Entered in R_ADDR with master m holding arvalid; completes the AR and len+1 beats.
  task automatic do_read(input int m, input int len, input int ard, input int gap,
                         input logic [AW-1:0] addr, input logic [DW-1:0] dbase);
    logic [DW-1:0] d; logic [IDW-1:0] id; logic [1:0] rs; int ng;
    for (int c = 0; c <= ard; c++) begin
      s_arready = (c == ard);
      #1;
      n_chk++;
      if (s_arvalid !== 1'b1 || s_araddr !== addr || s_arlen !== 8'(len)) begin
        n_fail++; $display("FAIL rd_ar: s_arvalid=%b s_araddr=%h s_arlen=%0d, want 1 %h %0d", s_arvalid, s_araddr, s_arlen, addr, len);
      end
      n_chk++;
      if ({m1_arready, m0_arready} !== (c == ard ? oh(m) : 2'b00)) begin
        n_fail++; $display("FAIL rd_arready: got %b want %b", {m1_arready, m0_arready}, (c == ard ? oh(m) : 2'b00));
      end
      @(negedge clock);
    end
    s_arready = 0;
    if (m == 0) m0_arvalid = 0; else m1_arvalid = 0;
    for (int b = 0; b <= len; b++) begin
      ng = (gap == 0) ? 0 : $urandom_range(gap, 1);
      for (int g = 0; g < ng; g++) begin
        s_rvalid = 0;
        #1;
        n_chk++;
        if (busy !== 1'b1 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
          n_fail++; $display("FAIL rd_gap: busy=%b rvalid=%b%b want 1 00", busy, m1_rvalid, m0_rvalid);
        end
        @(negedge clock);
      end
      d = dbase + DW'(b); id = IDW'($urandom); rs = 2'(b);
      s_rvalid = 1; s_rdata = d; s_rlast = (b == len); s_rid = id; s_rresp = rs;
      #1;
      n_chk++;
      if ({m1_rvalid, m0_rvalid} !== oh(m) || s_rready !== 1'b1) begin
        n_fail++; $display("FAIL rd_route: rvalid=%b s_rready=%b want %b 1", {m1_rvalid, m0_rvalid}, s_rready, oh(m));
      end
      n_chk++;
      if (((m == 0) ? {m0_rdata, m0_rid, m0_rresp, m0_rlast} : {m1_rdata, m1_rid, m1_rresp, m1_rlast})
          !== {d, id, rs, (b == len)}) begin
        n_fail++; $display("FAIL rd_data: master %0d beat %0d got %h want %h", m, b,
                           (m == 0) ? m0_rdata : m1_rdata, d);
      end
      @(negedge clock);
    end
    s_rvalid = 0; s_rlast = 0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || grant !== 2'b00) begin
      n_fail++; $display("FAIL rd_done: busy=%b grant=%b want 0 00", busy, grant);
    end
  endtask

  // Entered in W_DATA; AW ready after awd cycles, W ready after wd cycles, nb beats, B after bd cycles.
  task automatic do_write(input int awd, input int wd, input int nb, input int bd, input logic [1:0] bresp,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdb, input logic [DW/8-1:0] strb);
    logic aw_d; int wb; int c; logic [IDW-1:0] bid; logic [DW-1:0] wexp;
    aw_d = 0; wb = 0; c = 0;
    while (!(aw_d && wb == nb) && c < 40) begin
      wexp = wdb + DW'(wb);
      m1_awvalid = 1; m1_awaddr = addr; m1_wvalid = (wb < nb); m1_wdata = wexp;
      m1_wstrb = strb; m1_wlast = (wb == nb - 1);
      s_awready = (c >= awd); s_wready = (c >= wd);
      #1;
      n_chk++;
      if (s_awvalid !== !aw_d || (!aw_d && s_awaddr !== addr)) begin
        n_fail++; $display("FAIL wr_aw: s_awvalid=%b s_awaddr=%h want %b %h", s_awvalid, s_awaddr, !aw_d, addr);
      end
      n_chk++;
      if (s_wvalid !== (wb < nb) || (wb < nb && (s_wdata !== wexp || s_wstrb !== strb || s_wlast !== (wb == nb - 1)))) begin
        n_fail++; $display("FAIL wr_w: s_wvalid=%b s_wdata=%h s_wstrb=%h want %b %h %h", s_wvalid, s_wdata, s_wstrb, (wb < nb), wexp, strb);
      end
      n_chk++;
      if (s_bready !== 1'b0 || s_arvalid !== 1'b0 || m0_arready !== 1'b0 || busy !== 1'b1 || grant !== 2'b10) begin
        n_fail++; $display("FAIL wr_hold: s_bready=%b s_arvalid=%b m0_arready=%b busy=%b grant=%b want 0 0 0 1 10",
                           s_bready, s_arvalid, m0_arready, busy, grant);
      end
      if (!aw_d && s_awready) aw_d = 1;
      if (wb < nb && s_wready) wb++;
      c++;
      @(negedge clock);
    end
    n_chk++;
    if (!(aw_d && wb == nb)) begin
      n_fail++; $display("FAIL wr_timeout: aw_done=%b beats=%0d want 1 %0d", aw_d, wb, nb);
    end
    m1_awvalid = 0; m1_wvalid = 0; m1_wlast = 0; s_awready = 0; s_wready = 0;
    for (int i = 0; i < bd; i++) begin
      #1;
      n_chk++;
      if (busy !== 1'b1 || s_bready !== 1'b1 || m1_bvalid !== 1'b0 || s_awvalid !== 1'b0 || s_wvalid !== 1'b0) begin
        n_fail++; $display("FAIL wr_resp_wait: busy=%b s_bready=%b m1_bvalid=%b want 1 1 0", busy, s_bready, m1_bvalid);
      end
      @(negedge clock);
    end
    bid = IDW'($urandom);
    s_bvalid = 1; s_bresp = bresp; s_bid = bid;
    #1;
    n_chk++;
    if (m1_bvalid !== 1'b1 || m1_bresp !== bresp || m1_bid !== bid || s_bready !== 1'b1) begin
      n_fail++; $display("FAIL wr_b: m1_bvalid=%b m1_bresp=%0d m1_bid=%h s_bready=%b want 1 %0d %h 1",
                         m1_bvalid, m1_bresp, m1_bid, s_bready, bresp, bid);
    end
    @(negedge clock);
    s_bvalid = 0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || grant !== 2'b00) begin
      n_fail++; $display("FAIL wr_done: busy=%b grant=%b want 0 00", busy, grant);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (busy !== 1'b0 || grant !== 2'b00 || s_arvalid !== 0 || s_awvalid !== 0 || s_wvalid !== 0 ||
        s_rready !== 0 || s_bready !== 0 || m0_arready !== 0 || m1_arready !== 0 || m1_awready !== 0) begin
      n_fail++; $display("FAIL reset_state: busy=%b grant=%b s_arvalid=%b s_awvalid=%b want all 0", busy, grant, s_arvalid, s_awvalid);
    end
  endtask

  task automatic test_single_read();
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arid = 4'h3; m0_arlen = 0; s_arready = 1;
    #1;
    n_chk++;
    if (s_arvalid !== 1'b0 || m0_arready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_latency: s_arvalid=%b m0_arready=%b busy=%b want 0 0 0", s_arvalid, m0_arready, busy);
    end
    @(negedge clock); #1;
    n_chk++;
    if (grant !== 2'b01 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_grant: grant=%b busy=%b want 01 1", grant, busy);
    end
    do_read(0, 0, 0, 0, 32'h8000_0000, 64'h1234);
    last_rd_m = 0;
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] a0, a1; int exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      a0 = $urandom; a1 = $urandom;
      m0_arvalid = 1; m0_araddr = a0; m0_arlen = 0;
      m1_arvalid = 1; m1_araddr = a1; m1_arlen = 0;
      @(negedge clock); #1;
      exp = (last_rd_m == 1) ? 0 : 1;
      n_chk++;
      if (grant !== oh(exp) || grant !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL rr_grant: round %0d grant=%b want %b", i, grant, oh(exp));
      end
      if (exp == 0) m1_arvalid = 0; else m0_arvalid = 0;
      do_read(exp, 0, $urandom_range(1, 0), 1, (exp == 0) ? a0 : a1, {$urandom, $urandom});
      last_rd_m = exp;
    end
  endtask

  task automatic test_write_priority();
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h8000_0100; m0_arlen = 0;
    m1_awvalid = 1; m1_awaddr = 32'h0f00_0004;
    m1_wvalid = 1; m1_wdata = 64'hAABB_CCDD_0000_0000; m1_wstrb = 8'hF0; m1_wlast = 1;
    #1;
    n_chk++;
    if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0 || s_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL wp_idle: s_awvalid=%b s_wvalid=%b s_arvalid=%b want 000", s_awvalid, s_wvalid, s_arvalid);
    end
    @(negedge clock); #1;
    n_chk++;
    if (grant !== 2'b10 || s_awvalid !== 1'b1) begin
      n_fail++; $display("FAIL wp_grant: grant=%b s_awvalid=%b want 10 1", grant, s_awvalid);
    end
    do_write(0, 0, 1, 1, 2'b00, 32'h0f00_0004, 64'hAABB_CCDD_0000_0000, 8'hF0);
    n_chk++;
    if (s_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL wp_read_early: s_arvalid=%b want 0", s_arvalid);
    end
    @(negedge clock); #1;
    n_chk++;
    if (grant !== 2'b01 || s_arvalid !== 1'b1) begin
      n_fail++; $display("FAIL wp_read_after: grant=%b s_arvalid=%b want 01 1", grant, s_arvalid);
    end
    do_read(0, 0, 0, 0, 32'h8000_0100, {$urandom, $urandom});
    last_rd_m = 0;
  endtask

  task automatic test_w_before_aw();
    @(negedge clock);
    m1_awvalid = 1; m1_awaddr = 32'h1000_0040;
    @(negedge clock); #1;
    n_chk++;
    if (grant !== 2'b10) begin
      n_fail++; $display("FAIL wba_grant: grant=%b want 10", grant);
    end
    do_write(2, 0, 1, 1, 2'b10, 32'h1000_0040, 64'h0123_4567_89AB_CDEF, 8'hFF);
  endtask

  task automatic test_burst();
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h8000_2000; m0_arlen = 8'd3;
    @(negedge clock); #1;
    n_chk++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL burst_grant: grant=%b want 01", grant);
    end
    do_read(0, 3, 1, 2, 32'h8000_2000, {$urandom, $urandom});
    m0_arlen = 0;
    last_rd_m = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    m0_arvalid = 1; m0_araddr = 32'h8000_3000; s_arready = 1;
    @(negedge clock);
    @(negedge clock);
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rlast = 0; s_rdata = 64'hDEAD;
    #1;
    n_chk++;
    if (busy !== 1'b1 || m0_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL rm_in_rdata: busy=%b m0_rvalid=%b want 1 1", busy, m0_rvalid);
    end
    reset = 1;
    @(negedge clock);
    reset = 0; s_rvalid = 0;
    last_rd_m = 1;
    #1;
    n_chk++;
    if (busy !== 0 || grant !== 2'b00 || s_arvalid !== 0 || s_rready !== 0 || m0_rvalid !== 0 || m1_rvalid !== 0 || s_awvalid !== 0) begin
      n_fail++; $display("FAIL rm_after_reset: busy=%b grant=%b s_rready=%b m0_rvalid=%b want 0 00 0 0", busy, grant, s_rready, m0_rvalid);
    end
    @(negedge clock);
    m1_arvalid = 1; m1_araddr = 32'h0000_8000; m1_arlen = 0;
    @(negedge clock); #1;
    n_chk++;
    if (grant !== 2'b10) begin
      n_fail++; $display("FAIL rm_fresh_grant: grant=%b want 10", grant);
    end
    do_read(1, 0, 1, 1, 32'h0000_8000, {$urandom, $urandom});
    last_rd_m = 1;
  endtask

  task automatic test_random();
    logic [2:0] r; logic [AW-1:0] a0, a1, aw; int exp; int len;
    for (int it = 0; it < 24; it++) begin
      @(negedge clock);
      r = 3'($urandom_range(7, 1));
      a0 = $urandom; a1 = $urandom; aw = $urandom; len = $urandom_range(3, 0);
      m0_arvalid = r[0]; m0_araddr = a0; m0_arlen = 8'(len);
      m1_arvalid = r[1]; m1_araddr = a1; m1_arlen = 8'(len);
      m1_awvalid = r[2]; m1_awaddr = aw;
      #1;
      n_chk++;
      if (busy !== 1'b0 || s_arvalid !== 1'b0 || s_awvalid !== 1'b0) begin
        n_fail++; $display("FAIL rnd_idle: it %0d busy=%b s_arvalid=%b s_awvalid=%b want 000", it, busy, s_arvalid, s_awvalid);
      end
      @(negedge clock); #1;
      if (r[2]) exp = 2;
      else if (r[0] && r[1]) exp = (last_rd_m == 1) ? 0 : 1;
      else exp = r[0] ? 0 : 1;
      n_chk++;
      if (grant !== ((exp == 2) ? 2'b10 : oh(exp)) || s_awvalid !== (exp == 2) || s_arvalid !== (exp != 2)) begin
        n_fail++; $display("FAIL rnd_grant: it %0d req=%b grant=%b s_awvalid=%b s_arvalid=%b want owner %0d",
                           it, r, grant, s_awvalid, s_arvalid, exp);
      end
      if (exp == 2) begin
        m0_arvalid = 0; m1_arvalid = 0;
        do_write($urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(3, 1), $urandom_range(2, 0),
                 2'($urandom), aw, {$urandom, $urandom}, 8'($urandom));
      end else begin
        if (exp == 0) m1_arvalid = 0; else m0_arvalid = 0;
        do_read(exp, len, $urandom_range(2, 0), $urandom_range(2, 0), (exp == 0) ? a0 : a1, {$urandom, $urandom});
        last_rd_m = exp;
      end
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    last_rd_m = 1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_priority();
    test_w_before_aw();
    test_burst();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060059_axi_arbiter.md
Name: ysyx_23060059_axi_arbiter

Overview:
Arbitrates the single AXI4 memory port between the IFU (master 0, read-only) and the LSU (master 1, read/write). It sits between the core fetch/load-store units and the SoC crossbar. Exactly one transaction is outstanding at a time. Reads are granted round-robin; a pending LSU write has priority over any read.

Parameters:
AW, 32, address width
DW, 64, data width
IDW, 4, AXI id width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_arvalid/m0_arready  in/out  1/1  IFU AR handshake
m0_araddr/m0_arid/m0_arlen/m0_arsize/m0_arburst  in  AW/IDW/8/3/2  IFU AR payload
m0_rvalid/m0_rready  out/in  1/1  IFU R handshake
m0_rdata/m0_rresp/m0_rlast/m0_rid  out  DW/2/1/IDW  IFU R payload
m1_ar*, m1_r*  same set and widths as m0  LSU read channels
m1_awvalid/m1_awready  in/out  1/1  LSU AW handshake
m1_awaddr/m1_awid/m1_awlen/m1_awsize/m1_awburst  in  AW/IDW/8/3/2  LSU AW payload
m1_wvalid/m1_wready  in/out  1/1  LSU W handshake
m1_wdata/m1_wstrb/m1_wlast  in  DW/DW/8/1  LSU W payload
m1_bvalid/m1_bready  out/in  1/1  LSU B handshake
m1_bresp/m1_bid  out  2/IDW  LSU B payload
s_ar*, s_r*, s_aw*, s_w*, s_b*  mirrored directions  same widths  slave-side AXI port
busy  out  1  state != IDLE
grant  out  2  one-hot {m1,m0} of the owning master; 0 in IDLE

Behaviour:
- States: IDLE, R_ADDR, R_DATA, W_DATA, W_RESP. State and grant are registered.
- IDLE:
  - m1_awvalid=1 → W_DATA, grant=m1. Write wins even if ARs are also pending.
  - Else exactly one arvalid → R_ADDR with that master.
  - Else both arvalid → R_ADDR with the master not equal to last_rd.
  - Else stay in IDLE.
- Arbitration latency: a request seen in IDLE at cycle t drives s_arvalid/s_awvalid from t+1.
- R_ADDR:
  - s_arvalid = granted arvalid; s_ar* payload = granted payload; granted arready = s_arready.
  - Non-granted arready = 0.
  - On s_arvalid && s_arready → R_DATA.
- R_DATA:
  - s_r* routed to the granted master only; s_rready = granted rready.
  - Non-granted rvalid = 0.
  - On a handshake with rlast=1 → IDLE, and last_rd ← granted.
  - Bursts of any arlen pass through with no beat counting.
- W_DATA:
  - AW and W handshake independently; aw_done/w_done flags are set on their handshakes.
  - Once aw_done is set, s_awvalid is masked to 0.
  - The W channel stays open until a beat with wlast=1 is accepted.
  - When both flags are set (the same-cycle case counts) → W_RESP, and the flags clear.
- W_RESP: s_b* routed to m1; on bvalid && bready → IDLE.
- Read data/resp/id and bresp are passed through unmodified; the arbiter does not check errors.
- In IDLE, all slave valids/readies are 0 and all master readies/valids are 0. There is no combinational path from any master valid to the slave in IDLE.
- Reset values:
  - State = IDLE, grant = 0, busy = 0.
  - last_rd = m1, so IFU wins the first tie.
  - aw_done = w_done = 0; all outputs 0.
- Reset mid-transaction: the transaction is abandoned immediately and outputs go to 0 the next cycle. The slave is reset by the same signal.
- Masters must hold valid and payload stable until handshake (AXI rule). A master dropping valid while not granted is legal.

Test Plan:
1. m0 AR to 0x8000_0000 alone; slave arready at once, 1 rdata=0x1234 rlast=1 → m0 receives 0x1234. The AR reaches the slave 1 cycle after request. m1_rvalid stays 0 throughout.
2. m0 and m1 AR in the same cycle, repeated 4 times → grants alternate m0, m1, m0, m1; each r routed only to its requester.
3. m1 AW 0x0f00_0004 + W wdata=0xAABB_CCDD_0000_0000 wstrb=0xF0 while m0_arvalid=1 → write is granted first; the read starts only after the B handshake.
4. Slave accepts W two cycles before AW → W_RESP is entered only after the AW handshake; bresp=2 is passed to m1 unchanged.
5. arlen=3 burst for m0 with slave rvalid gaps → all 4 beats are forwarded and the arbiter returns to IDLE only on the rlast beat.
6. Assert reset in R_DATA → next cycle busy=0, grant=0, all valids 0. A fresh m1 AR afterwards completes normally.
